// File: rtl/ram_pkg.sv
// Shared constants for the multi-port RAM: default geometry and the clear-engine
// state encoding.
package ram_pkg;

  localparam int A_DEF  = 10;
  localparam int D_DEF  = 8;
  localparam int CH_DEF = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  // Priority pointer width; a single channel still needs a 1-bit pointer.
  function automatic int ptr_w(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requesting channel at or after
// ptr, wrapping around to channel 0.
module rr_arbiter
  import ram_pkg::*;
#(
  parameter int CH = CH_DEF
) (
  input  logic [CH-1:0]          req,
  input  logic [ptr_w(CH)-1:0]   ptr,
  output logic [CH-1:0]          gnt
);

  logic found;

  // First pass covers ptr..CH-1, second pass covers the wrapped part 0..ptr-1.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int j = 0; j < CH; j++) begin
      if (!found && req[j] && (j >= int'(ptr))) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int j = 0; j < CH; j++) begin
      if (!found && req[j] && (j < int'(ptr))) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_mport.sv
// Multi-port single-bank RAM with round-robin access; reads return one cycle after
// the grant. Optional power-up clear engine enabled by RAM_MPORT_CLEAR_EN.
//
// state    | meaning
// ST_CLEAR | zeroing mem[clr_cnt] each cycle, requests blocked (busy=1)
// ST_IDLE  | normal arbitrated access
module ram_mport
  import ram_pkg::*;
#(
  parameter int A  = A_DEF,
  parameter int D  = D_DEF,
  parameter int CH = CH_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [CH-1:0]   req,
  input  logic [CH-1:0]   we,
  input  logic [CH*A-1:0] addr,
  input  logic [CH*D-1:0] din,
  output logic [CH-1:0]   gnt,
  output logic [D-1:0]    dout,
  output logic [CH-1:0]   rvalid,
  output logic            busy
);

  localparam int PW = ptr_w(CH);

  logic [D-1:0]  mem [0:(2**A)-1];
  logic [PW-1:0] ptr;
  logic [PW-1:0] nxt_ptr;
  logic [CH-1:0] req_ok;
  logic [A-1:0]  sel_addr;
  logic [D-1:0]  sel_din;
  logic          sel_we;
  logic          any_gnt;

`ifdef RAM_MPORT_CLEAR_EN
  clr_state_t state, state_nxt;
  logic [A-1:0] clr_cnt, clr_cnt_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      ST_CLEAR: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (&clr_cnt) state_nxt = ST_IDLE;
      end
      ST_IDLE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_CLEAR);
`else
  assign busy = 1'b0;
`endif

  assign req_ok = req & {CH{~busy}};

  rr_arbiter #(.CH(CH)) u_arb (
    .req (req_ok),
    .ptr (ptr),
    .gnt (gnt)
  );

  always_comb begin
    sel_addr = '0;
    sel_din  = '0;
    sel_we   = 1'b0;
    nxt_ptr  = ptr;
    any_gnt  = |gnt;
    for (int k = 0; k < CH; k++) begin
      if (gnt[k]) begin
        sel_addr = addr[k*A +: A];
        sel_din  = din[k*D +: D];
        sel_we   = we[k];
        nxt_ptr  = (k == CH - 1) ? '0 : PW'(k + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (any_gnt) begin
      ptr <= nxt_ptr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout   <= '0;
      rvalid <= '0;
    end else begin
      rvalid <= gnt & ~we;
      if (any_gnt && !sel_we) dout <= mem[sel_addr];
    end
  end

  // Storage has no reset so it can map onto a RAM macro.
  always_ff @(posedge clk) begin
`ifdef RAM_MPORT_CLEAR_EN
    if (busy) begin
      mem[clr_cnt] <= '0;
    end else if (any_gnt && sel_we) begin
      mem[sel_addr] <= sel_din;
    end
`else
    if (any_gnt && sel_we) begin
      mem[sel_addr] <= sel_din;
    end
`endif
  end

endmodule

// File: tb/tb_ram_mport.sv
// Self-checking bench for ram_mport: table-driven arbitration vectors, directed
// corner sequences and randomized traffic against a behavioural model.
module tb_ram_mport;

  localparam int CH = 4;
  localparam int D  = 8;
`ifdef RAM_MPORT_CLEAR_EN
  localparam int A   = 4;
  localparam bit CLR = 1'b1;
`else
  localparam int A   = 6;
  localparam bit CLR = 1'b0;
`endif
  localparam int DEPTH = 1 << A;

  logic            clk;
  logic            reset_n;
  logic [CH-1:0]   req;
  logic [CH-1:0]   we;
  logic [CH*A-1:0] addr;
  logic [CH*D-1:0] din;
  logic [CH-1:0]   gnt;
  logic [D-1:0]    dout;
  logic [CH-1:0]   rvalid;
  logic            busy;

  ram_mport #(.A(A), .D(D), .CH(CH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .din     (din),
    .gnt     (gnt),
    .dout    (dout),
    .rvalid  (rvalid),
    .busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int m_ptr;
  int m_mem [DEPTH];
  bit m_known [DEPTH];
  int m_dout;
  bit m_dout_known;
  int m_rvalid;
  int m_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [CH-1:0] r);
    for (int i = 0; i < CH; i++) begin
      int c;
      c = (m_ptr + i) % CH;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [CH*A-1:0] rep_a(input int x);
    logic [A-1:0] t;
    t = A'(x);
    return {CH{t}};
  endfunction

  function automatic logic [CH*D-1:0] rep_d(input int x);
    logic [D-1:0] t;
    t = D'(x);
    return {CH{t}};
  endfunction

  task automatic model_reset();
    m_ptr        = 0;
    m_dout       = 0;
    m_dout_known = 1'b1;
    m_rvalid     = 0;
    m_busy       = CLR ? DEPTH : 0;
    if (CLR) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]   = 0;
        m_known[i] = 1'b1;
      end
    end
  endtask

  // One clock: drive at posedge+1, check at negedge, advance model, end at posedge+1.
  task automatic cycle(input logic [CH-1:0] r, input logic [CH-1:0] w,
                       input logic [CH*A-1:0] a, input logic [CH*D-1:0] d,
                       output logic [CH-1:0] gs);
    int g;
    int ad;
    req  = r;
    we   = w;
    addr = a;
    din  = d;
    @(negedge clk);
    gs = gnt;
    g  = (m_busy > 0) ? -1 : pick(r);
    chk("gnt", gnt, (g < 0) ? 0 : (1 << g));
    chk("rvalid", rvalid, m_rvalid);
    if (m_dout_known) chk("dout", dout, m_dout);
    chk("busy", busy, (m_busy > 0) ? 1 : 0);
    if (m_busy > 0) m_busy--;
    m_rvalid = 0;
    if (g >= 0) begin
      ad = int'(a[g*A +: A]);
      if (w[g]) begin
        m_mem[ad]   = int'(d[g*D +: D]);
        m_known[ad] = 1'b1;
      end else begin
        m_dout       = m_mem[ad];
        m_dout_known = m_known[ad];
        m_rvalid     = 1 << g;
      end
      m_ptr = (g + 1) % CH;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [CH-1:0] r, input logic [CH-1:0] w,
                      input logic [CH*A-1:0] a, input logic [CH*D-1:0] d);
    logic [CH-1:0] gs;
    cycle(r, w, a, d, gs);
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_rvalid", rvalid, 0);
    chk("rst_dout", dout, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic settle();
    if (CLR) begin
      for (int i = 0; i < DEPTH; i++) step('0, '0, '0, '0);
    end
  endtask

  typedef struct {
    logic [CH-1:0] r;
    logic [CH-1:0] w;
    logic [CH-1:0] g;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [CH-1:0] gs;
    logic [31:0]   rv;

    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]   = 0;
      m_known[i] = 1'b0;
    end
    reset_n = 1'b1;
    req = '0; we = '0; addr = '0; din = '0;
    @(posedge clk);
    #1;
    do_reset();

    if (CLR) begin
      // Requests are locked out for the whole clear, then memory reads as zero.
      for (int i = 0; i < DEPTH; i++) step('1, '0, rep_a(i), '0);
      step('0, '0, '0, '0);
      do_reset();
      for (int i = 0; i < 5; i++) step('1, '0, '0, '0);
      do_reset();
      for (int i = 0; i < DEPTH; i++) step('1, '1, rep_a(i), rep_d(8'hFF));
      for (int i = 0; i < DEPTH; i++) step(4'b0001, '0, rep_a(i), '0);
      step('0, '0, '0, '0);
    end

    // Arbitration table, starting from reset priority.
    tbl[0]  = '{4'b1111, 4'b1111, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b1111, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b1111, 4'b0100};
    tbl[3]  = '{4'b1111, 4'b1111, 4'b1000};
    tbl[4]  = '{4'b1111, 4'b1111, 4'b0001};
    tbl[5]  = '{4'b1111, 4'b1111, 4'b0010};
    tbl[6]  = '{4'b1111, 4'b1111, 4'b0100};
    tbl[7]  = '{4'b1111, 4'b1111, 4'b1000};
    tbl[8]  = '{4'b0010, 4'b1111, 4'b0010};
    tbl[9]  = '{4'b1001, 4'b1111, 4'b1000};
    tbl[10] = '{4'b1001, 4'b1111, 4'b0001};
    tbl[11] = '{4'b0000, 4'b1111, 4'b0000};
    do_reset();
    settle();
    for (int i = 0; i < 12; i++) begin
      rv = $urandom;
      cycle(tbl[i].r, tbl[i].w, rep_a(int'(rv[15:8])), rep_d(int'(rv[7:0])), gs);
      chk("tbl_gnt", gs, tbl[i].g);
    end

    // Write then read-after-write from another channel.
    step(4'b0001, 4'b0001, rep_a('h010), rep_d('h5A));
    step(4'b0010, 4'b0000, rep_a('h010), '0);
    chk("raw_dout", dout, 'h5A);
    chk("raw_rvalid", rvalid, 4'b0010);
    step('0, '0, '0, '0);
    chk("raw_rvalid_drop", rvalid, 0);

    // Pending read result discarded by reset.
    step(4'b0001, 4'b0000, rep_a('h010), '0);
    do_reset();
    settle();
    step('0, '0, '0, '0);
    chk("rst_no_rvalid", rvalid, 0);
    chk("rst_dout_zero", dout, 0);

    // ch2 withdraws before being granted; its write must never land.
    step(4'b1000, 4'b1000, rep_a(5), rep_d('h33));
    step(4'b0111, 4'b0100, rep_a(5), rep_d('hEE));
    step(4'b0111, 4'b0100, rep_a(5), rep_d('hEE));
    step(4'b0000, 4'b0000, rep_a(5), '0);
    chk("drop_rvalid2", rvalid[2], 0);
    step(4'b0001, 4'b0000, rep_a(5), '0);
    chk("drop_dout", dout, 'h33);

    for (int i = 0; i < DEPTH; i++) begin
      rv = $urandom;
      step(4'b0001, 4'b0001, rep_a(i), rep_d(int'(rv[7:0])));
    end

    for (int n = 0; n < 400; n++) begin
      logic [CH-1:0]   r, w;
      logic [CH*A-1:0] a;
      logic [CH*D-1:0] d;
      rv = $urandom; r = rv[CH-1:0]; w = rv[2*CH-1:CH];
      rv = $urandom; a = rv[CH*A-1:0];
      rv = $urandom; d = rv[CH*D-1:0];
      step(r, w, a, d);
    end
    step('0, '0, '0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_mport.md
RAM_MPORT -- requirements
Module: ram_mport

Interface
- REQ-001: Parameter A, default 10: number of address bits; depth is 2**A words.
- REQ-002: Parameter D, default 8: number of data bits per word.
- REQ-003: Parameter CH, default 4: number of requester channels, 1..8.
- REQ-004: Port clk, input, 1: the single clock; all state changes on the rising edge.
- REQ-005: Port reset_n, input, 1: asynchronous, active-low reset.
- REQ-006: Port req, input, CH: per-channel access request, held high until granted.
- REQ-007: Port we, input, CH: per-channel write enable, sampled with req.
- REQ-008: Port addr, input, CH*A: per-channel address; channel k occupies bits [k*A +: A].
- REQ-009: Port din, input, CH*D: per-channel write data; channel k occupies bits [k*D +: D].
- REQ-010: Port gnt, output, CH: one-hot combinational grant; the access is performed at the edge where gnt[k] is high.
- REQ-011: Port dout, output, D: shared registered read data.
- REQ-012: Port rvalid, output, CH: registered one-cycle pulse marking dout as valid for channel k.
- REQ-013: Port busy, output, 1: high while the block cannot accept requests.

Function
- REQ-014: At most one gnt bit is high per cycle; gnt is all-zero when busy is high or req is zero.
- REQ-015: Arbitration is round-robin; after a grant to channel k, priority order starts at k+1 modulo CH; reset priority starts at channel 0.
- REQ-016: The priority pointer advances only on a cycle with a grant.
- REQ-017: Granted write: mem[addr_k] is updated with din_k at the edge; no rvalid is produced.
- REQ-018: Granted read: dout = mem[addr_k] and rvalid[k] = 1 on the cycle after the grant edge; read latency is exactly 1.
- REQ-019: rvalid is zero on every cycle not following a granted read.
- REQ-020: dout holds its last value when rvalid is zero.
- REQ-021: A read granted on the cycle after a write to the same address returns the new data.
- REQ-022: A requester may drop req before it is granted; no access occurs for that channel.
- REQ-023: With all CH channels requesting continuously, each channel is granted exactly once per CH cycles.
- REQ-024: Address wrap is not applicable; addr is exactly A bits, so every address is legal.

Reset
- REQ-025: Assertion of reset_n low immediately forces rvalid=0, dout=0, and priority pointer=0.
- REQ-026: Memory contents are undefined after reset unless RAM_MPORT_CLEAR_EN is defined.
- REQ-027: Reset asserted mid-operation discards any pending read result; no rvalid follows deassertion.

Configuration
- REQ-028: Macro RAM_MPORT_CLEAR_EN, when defined, adds a clear engine with states IDLE and CLEAR.
- REQ-029: With RAM_MPORT_CLEAR_EN defined, reset enters CLEAR with counter 0 and busy=1.
- REQ-030: In CLEAR, the engine writes 0 to mem[counter] each cycle and increments the counter.
- REQ-031: After writing address 2**A-1, the engine enters IDLE and drops busy on the following cycle; a clear lasts 2**A cycles.
- REQ-032: Reset during CLEAR restarts the clear from address 0.
- REQ-033: Without RAM_MPORT_CLEAR_EN, busy is constant 0 and there is no clear logic.

Structure
- REQ-034: Shared package ram_pkg holds the default A/D/CH constants and the IDLE/CLEAR state encoding.
- REQ-035: Round-robin selection is a sub-module rr_arbiter (parameter CH; inputs req and pointer; output one-hot gnt).

Verification
- REQ-036: CH=4: ch0 writes 0x5A to address 0x010; next cycle ch1 reads 0x010 -> one cycle later dout=0x5A and rvalid=0010.
- REQ-037: req=1111 held for 8 cycles from reset -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000.
- REQ-038: Pointer after a grant to ch1, then req=1001 -> ch3 granted first, then ch0.
- REQ-039: Read granted, then reset_n pulsed low before the next edge -> rvalid stays 0 and dout=0.
- REQ-040: With RAM_MPORT_CLEAR_EN, A=4: busy=1 for 16 cycles after reset, gnt=0 with req=1111 throughout, then reads of addresses 0..15 all return 0.
- REQ-041: ch2 drops req after 2 ungranted cycles while ch0 holds priority -> no access for ch2 and no rvalid[2].
